// File: rtl/chunked_carry_adder.sv
// Multi-cycle wide adder: one CHUNK_WIDTH slice per clock, LSB slice first.
// Optional subtract mode enabled by defining CHUNKED_CARRY_ADDER_SUBTRACT_EN.

module carry_forecast #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             c_o
);
    // Generate/propagate chain across the slice
    always_comb begin
        logic c;
        c = c_i;
        for (int i = 0; i < WIDTH; i++) begin
            c = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & c);
        end
        c_o = c;
    end
endmodule

module chunked_carry_adder #(
    parameter int CHUNK_WIDTH     = 4,
    parameter int NUMBER_OF_CHUNK = 4,
    localparam int TOTAL_WIDTH    = CHUNK_WIDTH * NUMBER_OF_CHUNK
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] operand1,
    input  logic [TOTAL_WIDTH-1:0] operand2,
    input  logic                   carry_in,
`ifdef CHUNKED_CARRY_ADDER_SUBTRACT_EN
    input  logic                   subtract,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] sum,
    output logic                   carry_out,
    output logic                   and_result,
    output logic                   busy
);
    localparam int IDX_W = (NUMBER_OF_CHUNK > 1) ? $clog2(NUMBER_OF_CHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [TOTAL_WIDTH-1:0] op1_q;
    logic [TOTAL_WIDTH-1:0] op2_q;
    logic                   carry_q;
    logic [TOTAL_WIDTH-1:0] sum_q;
    logic                   carryOut_q;
    logic                   and_q;
    logic                   outValid_q;
    logic                   busy_q;
    logic                   sub_q;

    logic [CHUNK_WIDTH-1:0] sliceA;
    logic [CHUNK_WIDTH-1:0] sliceB;
    logic [CHUNK_WIDTH:0]   sliceFull;
    logic [CHUNK_WIDTH-1:0] sliceSum_d;
    logic                   carry_d;
    logic                   lastSlice;

    assign sliceA     = op1_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign sliceB     = op2_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign sliceFull  = {1'b0, sliceA} + {1'b0, sliceB} + {{CHUNK_WIDTH{1'b0}}, carry_q};
    assign sliceSum_d = sliceFull[CHUNK_WIDTH-1:0];
    assign lastSlice  = (idx_q == IDX_W'(NUMBER_OF_CHUNK - 1));

    carry_forecast #(.WIDTH(CHUNK_WIDTH)) u_forecast (
        .a_i (sliceA),
        .b_i (sliceB),
        .c_i (carry_q),
        .c_o (carry_d)
    );

    // Operands are stored already inverted in subtract mode, so RUN is pure addition
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            carry_q    <= 1'b0;
            sum_q      <= '0;
            carryOut_q <= 1'b0;
            and_q      <= 1'b0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            sub_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op1_q   <= operand1;
`ifdef CHUNKED_CARRY_ADDER_SUBTRACT_EN
                        op2_q   <= subtract ? ~operand2 : operand2;
                        carry_q <= carry_in ^ subtract;
                        sub_q   <= subtract;
`else
                        op2_q   <= operand2;
                        carry_q <= carry_in;
                        sub_q   <= 1'b0;
`endif
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] <= sliceSum_d;
                    carry_q <= carry_d;
                    if (lastSlice) begin
                        carryOut_q <= carry_d ^ sub_q;
                        and_q      <= op1_q[TOTAL_WIDTH-1] & op2_q[TOTAL_WIDTH-1];
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = outValid_q;
    assign sum        = sum_q;
    assign carry_out  = carryOut_q;
    assign and_result = and_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_chunked_carry_adder.sv
// Self-checking bench for chunked_carry_adder against an arithmetic reference model.
module tb_chunked_carry_adder;
   localparam int CW = 4;
   localparam int NC = 4;
   localparam int TW = CW * NC;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [TW-1:0] operand1;
   logic [TW-1:0] operand2;
   logic          carry_in;
   logic          subtract;
   logic          out_valid;
   logic          out_ready;
   logic [TW-1:0] sum;
   logic          carry_out;
   logic          and_result;
   logic          busy;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      logic [TW-1:0] sum;
      logic          cout;
      logic          andr;
   } result_t;

   result_t expQ[$];

   always #5 clock = ~clock;

   chunked_carry_adder #(.CHUNK_WIDTH(CW), .NUMBER_OF_CHUNK(NC)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .operand1   (operand1),
      .operand2   (operand2),
      .carry_in   (carry_in),
`ifdef CHUNKED_CARRY_ADDER_SUBTRACT_EN
      .subtract   (subtract),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sum        (sum),
      .carry_out  (carry_out),
      .and_result (and_result),
      .busy       (busy)
   );

   // Reference model: whole-word arithmetic, no slicing
   function automatic result_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                     input logic c, input logic s);
      result_t r;
      logic [TW:0] full;
      if (!s) begin
         full   = {1'b0, a} + {1'b0, b} + (TW+1)'(c);
         r.sum  = full[TW-1:0];
         r.cout = full[TW];
         r.andr = a[TW-1] & b[TW-1];
      end else begin
         r.sum  = a - b - TW'(c);
         r.cout = ({1'b0, a} < ({1'b0, b} + (TW+1)'(c)));
         r.andr = a[TW-1] & ~b[TW-1];
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full transaction; holdCycles keeps out_ready low in DONE while new data is offered
   task automatic applyStimulus(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                input logic c, input logic s, input int holdCycles);
      result_t r;
      int cycles;
      r = model(a, b, c, s);
      @(negedge clock);
      checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
      operand1 = a; operand2 = b; carry_in = c; subtract = s; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         operand1 = TW'($urandom); operand2 = TW'($urandom);
         carry_in = 1'($urandom); subtract = 1'($urandom);
         @(posedge clock); #1;
         cycles++;
      end
      checkOutput("latency", 32'(cycles), 32'(NC));
      checkOutput("sum", 32'(sum), 32'(r.sum));
      checkOutput("carry_out", 32'(carry_out), 32'(r.cout));
      checkOutput("and_result", 32'(and_result), 32'(r.andr));
      checkOutput("busy_done", 32'(busy), 32'd1);
      checkOutput("in_ready_done", 32'(in_ready), 32'd0);
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clock);
         operand1 = TW'($urandom); operand2 = TW'($urandom); in_valid = 1'b1;
         @(posedge clock); #1;
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_sum", 32'(sum), 32'(r.sum));
         checkOutput("hold_cout", 32'(carry_out), 32'(r.cout));
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      checkOutput("release_valid", 32'(out_valid), 32'd0);
      checkOutput("release_in_ready", 32'(in_ready), 32'd1);
      checkOutput("release_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      result_t r;
      int lastValid;
      reset = 1'b1; in_valid = 1'b1; operand1 = 16'hAAAA; operand2 = 16'h5555;
      carry_in = 1'b1; subtract = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_sum", 32'(sum), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_cout", 32'(carry_out), 32'd0);
      @(negedge clock);
      reset = 1'b0; in_valid = 1'b0;
      @(posedge clock); #1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("no_latch_in_reset", 32'(busy), 32'd0);

      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0, 0);
      applyStimulus(16'h0FFF, 16'h0001, 1'b0, 1'b0, 0);
      applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 5);

      // Abort two cycles into RUN
      @(negedge clock);
      operand1 = 16'h7777; operand2 = 16'h1111; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checkOutput("abort_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_sum", 32'(sum), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(TW'($urandom), TW'($urandom), 1'($urandom), 1'b0, (i == 3) ? 2 : 0);
      end

`ifdef CHUNKED_CARRY_ADDER_SUBTRACT_EN
      applyStimulus(16'd5, 16'd3, 1'b0, 1'b1, 0);
      applyStimulus(16'd3, 16'd5, 1'b0, 1'b1, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(TW'($urandom), TW'($urandom), 1'($urandom), 1'($urandom), 0);
      end
`endif

      // Back-to-back streaming with operands changing every cycle
      out_ready = 1'b1;
      lastValid = -1;
      for (int cyc = 0; cyc < 45; cyc++) begin
         @(negedge clock);
         if (out_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("stream_unexpected", 32'd1, 32'd0);
            end else begin
               r = expQ.pop_front();
               checkOutput("stream_sum", 32'(sum), 32'(r.sum));
               checkOutput("stream_cout", 32'(carry_out), 32'(r.cout));
            end
            if (lastValid >= 0) checkOutput("stream_interval", 32'(cyc - lastValid), 32'(NC + 2));
            lastValid = cyc;
         end
         if (cyc < 30) begin
            operand1 = TW'($urandom); operand2 = TW'($urandom);
            carry_in = 1'($urandom); in_valid = 1'b1;
            if (in_ready) expQ.push_back(model(operand1, operand2, carry_in, 1'b0));
         end else begin
            in_valid = 1'b0;
         end
      end
      checkOutput("stream_drained", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule

// File: doc/chunked_carry_adder.md
Name: chunked_carry_adder

Overview:
Multi-cycle wide adder. Splits operands of CHUNK_WIDTH*NUMBER_OF_CHUNK bits into CHUNK_WIDTH slices and adds one slice per clock, LSB slice first. The carry between slices comes from an internal carry_forecast instance of width CHUNK_WIDTH. It sits between arithmetic producers and consumers, with valid/ready handshakes on both sides.

Parameters:
CHUNK_WIDTH, 4, bit width of one slice; also the width of the internal carry_forecast instance
NUMBER_OF_CHUNK, 4, number of slices; must be >= 1
(derived) TOTAL_WIDTH = CHUNK_WIDTH*NUMBER_OF_CHUNK

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  operand request
in_ready  out  1  high only in IDLE
operand1  in  TOTAL_WIDTH  first operand
operand2  in  TOTAL_WIDTH  second operand
carry_in  in  1  input carry
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
sum  out  TOTAL_WIDTH  registered result
carry_out  out  1  carry out of MSB slice
and_result  out  1  operand1[MSB] & operand2[MSB], using latched operands
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (synchronous, checked first, overrides everything):
  - state <= IDLE; slice index <= 0.
  - sum, carry_out, and_result, out_valid, busy <= 0.
  - in_ready is 1 from the first cycle after reset deasserts.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch operand1, operand2 and carry_in into the running carry; index <= 0; go to RUN. Without in_valid, stay in IDLE.
  - RUN: each cycle, slice k = index:
    - sum[k*CHUNK_WIDTH +: CHUNK_WIDTH] <= op1_k + op2_k + carry, truncated to CHUNK_WIDTH.
    - carry <= carry_forecast(op1_k, op2_k, carry).
    - index <= index+1.
    - When index == NUMBER_OF_CHUNK-1: carry_out <= forecast carry; and_result <= latched MSB AND; go to DONE.
  - DONE: out_valid=1; sum, carry_out and and_result held stable. On out_ready, go to IDLE (out_valid <= 0).
- Timing:
  - Latency: accept at edge T means out_valid is high after edge T+NUMBER_OF_CHUNK.
  - Minimum initiation interval is NUMBER_OF_CHUNK+2 cycles. No accept is allowed in DONE.
- Input and output rules:
  - in_valid, operand and carry_in values are ignored outside IDLE. Latched operands are immune to later input changes.
  - Intermediate sum slices may be visible on sum during RUN; only the value under out_valid is guaranteed.
  - out_valid stays high indefinitely while out_ready=0; no result is dropped or overwritten.
- Boundary cases:
  - NUMBER_OF_CHUNK=1: RUN lasts one cycle.
  - Index counter width is max(1,$clog2(NUMBER_OF_CHUNK)). The index never wraps past NUMBER_OF_CHUNK-1.
  - Reset asserted in RUN or DONE aborts the operation; the next cycle is IDLE with all outputs 0.
  - Simultaneous reset and in_valid: reset wins, nothing is latched.

Optional Feature:
CHUNKED_CARRY_ADDER_SUBTRACT_EN
- Defined:
  - Adds input port subtract (1 bit), latched on accept.
  - When subtract=1: effective operand2 is ~operand2, effective carry is ~carry_in (carry_in acts as borrow-in), and carry_out is reported inverted (borrow-out).
  - and_result uses operand1 MSB & effective operand2 MSB.
- Undefined: no subtract port; pure addition as above.

Test Plan:
1. Defaults (16-bit): 0xFFFF+0x0001, carry_in=0 -> sum=0x0000, carry_out=1, and_result=0; out_valid rises exactly 4 cycles after accept edge.
2. 0x1234+0x4321, carry_in=1 -> sum=0x5556, carry_out=0. Then 0x0FFF+0x0001 -> 0x1000, carry_out=0 (inter-slice carry propagation).
3. 0x8000+0x8000 -> sum=0x0000, carry_out=1, and_result=1. Hold out_ready=0 for 5 cycles while driving in_valid with new data -> outputs stable, in_ready=0, new data not accepted.
4. Reset asserted 2 cycles into RUN -> next cycle state IDLE, out_valid=0, sum=0, in_ready=1. Then 0x0001+0x0001 -> sum=0x0002.
5. Back-to-back requests with out_ready tied 1 and in_valid tied 1 -> results 6 cycles apart; operands changed during RUN do not affect the result.
6. With SUBTRACT_EN, carry_in=0: 5-3 -> sum=0x0002, carry_out=0. 3-5 -> sum=0xFFFE, carry_out=1 (borrow).
